// File: rtl/adc_frontend_pkg.sv
// Shared types and widths for the ADC capture front end (word assembler -> sample framer).
package adc_frontend_pkg;

  localparam int unsigned ADC_WORD_W   = 16;
  localparam int unsigned ADC_SAMPLE_W = 14;
  localparam int unsigned ADC_PAD_W    = 2;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_RUN,
    FR_DRAIN
  } framer_state_t;

  typedef struct packed {
    logic                    last;
    logic [ADC_SAMPLE_W-1:0] data;
  } sample_entry_t;

endpackage

// File: rtl/sample_framer_if.sv
// Word input stream and framed sample output stream of the sample framer.
interface sample_framer_if;
  import adc_frontend_pkg::*;

  logic [ADC_WORD_W-1:0]   word;
  logic                    word_valid;
  logic                    word_ready;
  logic [ADC_SAMPLE_W-1:0] sample_data;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    sample_last;

  // Framer side: consumes words, produces samples.
  modport slave (
    input  word, word_valid, sample_ready,
    output word_ready, sample_data, sample_valid, sample_last
  );

  // Environment side: produces words, consumes samples.
  modport master (
    output word, word_valid, sample_ready,
    input  word_ready, sample_data, sample_valid, sample_last
  );
endinterface

// File: rtl/sample_skid_fifo.sv
// Two-entry in-order FIFO of sample entries; a push at fill=2 succeeds only alongside a pop.
module sample_skid_fifo
  import adc_frontend_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  sample_entry_t entry_i,
  input  logic          pop_i,
  output sample_entry_t head_o,
  output logic [1:0]    fill_o
);

  sample_entry_t mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    fill_q, fill_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (fill_q != 2'd0);
    do_push = push_i && ((fill_q != 2'd2) || do_pop);
    fill_d  = fill_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign fill_o = fill_q;

endmodule

// File: rtl/sample_framer.sv
// Strips pad bits from assembled words and frames 14-bit samples with a last marker.
// Build option: SAMPLE_FRAMER_TWOS_COMP_EN converts offset-binary samples to two's complement.
module sample_framer
  import adc_frontend_pkg::*;
#(
  parameter int unsigned WORD_W      = ADC_WORD_W,
  parameter int unsigned SAMPLE_W    = ADC_SAMPLE_W,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   dco_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  sample_framer_if.slave         stream_io,
  output logic                   busy,
  output logic                   pad_err,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  framer_state_t          state_q, state_d;
  logic [15:0]            idx_q, idx_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   pad_err_q, pad_err_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic                   accept, pop, idx_last;
  logic [1:0]             fill;
  sample_entry_t          entry_in, head;

  assign idx_last = (idx_q == 16'(FRAME_LEN - 1));
  // word_ready depends on registers only, so no ready/valid combinational loop is possible.
  assign stream_io.word_ready = (state_q == FR_RUN) && (fill != 2'd2);
  assign accept = stream_io.word_valid && stream_io.word_ready;
  assign pop    = stream_io.sample_ready && (fill != 2'd0);

  always_comb begin
    entry_in.last = idx_last;
`ifdef SAMPLE_FRAMER_TWOS_COMP_EN
    entry_in.data = {~stream_io.word[SAMPLE_W-1], stream_io.word[SAMPLE_W-2:0]};
`else
    entry_in.data = stream_io.word[SAMPLE_W-1:0];
`endif
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stop_pend_d   = stop_pend_q;
    pad_err_d     = pad_err_q;
    frame_count_d = frame_count_q;

    case (state_q)
      FR_IDLE: begin
        if (start) begin
          state_d = FR_RUN;
          idx_d   = '0;
        end
      end
      FR_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (accept) begin
          idx_d = idx_last ? '0 : idx_q + 16'd1;
          if (idx_last && (stop_pend_q || stop)) begin
            state_d     = FR_DRAIN;
            stop_pend_d = 1'b0;
          end
        end
      end
      FR_DRAIN: begin
        if (fill == 2'd0) state_d = FR_IDLE;
      end
      default: state_d = FR_IDLE;
    endcase

    if (accept && (stream_io.word[WORD_W-1 -: ADC_PAD_W] != '0)) pad_err_d = 1'b1;
    if (pop && head.last) frame_count_d = frame_count_q + FRAME_CNT_W'(1);
  end

  always_ff @(posedge dco_clk) begin
    if (rst) begin
      state_q       <= FR_IDLE;
      idx_q         <= '0;
      stop_pend_q   <= 1'b0;
      pad_err_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stop_pend_q   <= stop_pend_d;
      pad_err_q     <= pad_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  sample_skid_fifo u_fifo (
    .clk_i   (dco_clk),
    .rst_i   (rst),
    .push_i  (accept),
    .entry_i (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .fill_o  (fill)
  );

  assign stream_io.sample_valid = (fill != 2'd0);
  assign stream_io.sample_data  = head.data;
  assign stream_io.sample_last  = (fill != 2'd0) && head.last;
  assign busy        = (state_q != FR_IDLE);
  assign pad_err     = pad_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with FRAME_LEN=4; honours SAMPLE_FRAMER_TWOS_COMP_EN.
module tb_sample_framer;
  import adc_frontend_pkg::*;

  localparam int unsigned FL = 4;
  localparam int NV = 32;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic        busy, pad_err;
  logic [15:0] frame_count;

  sample_framer_if bus ();

  sample_framer #(.FRAME_LEN(FL)) dut (
    .dco_clk     (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .stream_io   (bus),
    .busy        (busy),
    .pad_err     (pad_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, stop, wv;
    logic [15:0] word;
    logic        sr;
    logic        e_wr, e_sv;
    logic [15:0] e_word;
    logic        e_last, e_busy, e_pad;
    int unsigned e_fc;
  } vec_t;

  vec_t vecs [NV];

  // Expected sample for a given input word in the current build.
  function automatic logic [13:0] xf(input logic [15:0] w);
`ifdef SAMPLE_FRAMER_TWOS_COMP_EN
    return {~w[13], w[12:0]};
`else
    return w[13:0];
`endif
  endfunction

  function automatic vec_t mk(input int st, input int sp, input int wv, input int w, input int sr,
                              input int wr, input int sv, input int d, input int l, input int b,
                              input int pe, input int fc);
    vec_t v;
    v.start = st[0]; v.stop = sp[0]; v.wv = wv[0]; v.word = w[15:0]; v.sr = sr[0];
    v.e_wr = wr[0]; v.e_sv = sv[0]; v.e_word = d[15:0]; v.e_last = l[0];
    v.e_busy = b[0]; v.e_pad = pe[0]; v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int st, input int sp, input int wv, input int w, input int sr);
    start = st[0];
    stop  = sp[0];
    bus.word_valid   = wv[0];
    bus.word         = w[15:0];
    bus.sample_ready = sr[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] tc_exp [3];

  initial begin
    //              st sp wv word     sr  wr sv data     l  b  pe fc
    vecs[0]  = mk(0, 0, 0, 'h0000, 1,  0, 0, 'h0000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 'h0000, 1,  0, 0, 'h0000, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 'h0001, 1,  1, 0, 'h0000, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 1, 'h0002, 1,  1, 1, 'h0001, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 1, 'h0003, 1,  1, 1, 'h0002, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 'h0004, 1,  1, 1, 'h0003, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 'h0000, 1,  1, 1, 'h0004, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 'h0000, 1,  1, 0, 'h0000, 0, 1, 0, 1);
    vecs[8]  = mk(0, 0, 1, 'h0011, 0,  1, 0, 'h0000, 0, 1, 0, 1);
    vecs[9]  = mk(0, 0, 1, 'h0012, 0,  1, 1, 'h0011, 0, 1, 0, 1);
    vecs[10] = mk(0, 0, 1, 'h0013, 0,  0, 1, 'h0011, 0, 1, 0, 1);
    vecs[11] = mk(0, 0, 1, 'h0013, 0,  0, 1, 'h0011, 0, 1, 0, 1);
    vecs[12] = mk(0, 0, 1, 'h0013, 1,  0, 1, 'h0011, 0, 1, 0, 1);
    vecs[13] = mk(0, 0, 1, 'h0013, 1,  1, 1, 'h0012, 0, 1, 0, 1);
    vecs[14] = mk(0, 0, 0, 'h0000, 1,  1, 1, 'h0013, 0, 1, 0, 1);
    vecs[15] = mk(0, 0, 0, 'h0000, 1,  1, 0, 'h0000, 0, 1, 0, 1);
    vecs[16] = mk(0, 0, 1, 'h0014, 1,  1, 0, 'h0000, 0, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 'h0000, 1,  1, 1, 'h0014, 1, 1, 0, 1);
    vecs[18] = mk(0, 0, 0, 'h0000, 1,  1, 0, 'h0000, 0, 1, 0, 2);
    vecs[19] = mk(0, 0, 1, 'h0021, 1,  1, 0, 'h0000, 0, 1, 0, 2);
    vecs[20] = mk(0, 0, 1, 'h0022, 1,  1, 1, 'h0021, 0, 1, 0, 2);
    vecs[21] = mk(0, 1, 0, 'h0000, 1,  1, 1, 'h0022, 0, 1, 0, 2);
    vecs[22] = mk(0, 0, 1, 'h0023, 1,  1, 0, 'h0000, 0, 1, 0, 2);
    vecs[23] = mk(0, 0, 1, 'h0024, 1,  1, 1, 'h0023, 0, 1, 0, 2);
    vecs[24] = mk(0, 0, 1, 'h0025, 1,  0, 1, 'h0024, 1, 1, 0, 2);
    vecs[25] = mk(0, 0, 1, 'h0025, 1,  0, 0, 'h0000, 0, 1, 0, 3);
    vecs[26] = mk(0, 0, 1, 'h0025, 1,  0, 0, 'h0000, 0, 0, 0, 3);
    vecs[27] = mk(1, 0, 0, 'h0000, 1,  0, 0, 'h0000, 0, 0, 0, 3);
    vecs[28] = mk(0, 0, 1, 'hC005, 1,  1, 0, 'h0000, 0, 1, 0, 3);
    vecs[29] = mk(0, 0, 1, 'h0006, 1,  1, 1, 'h0005, 0, 1, 1, 3);
    vecs[30] = mk(0, 0, 1, 'h0007, 1,  1, 1, 'h0006, 0, 1, 1, 3);
    vecs[31] = mk(0, 0, 0, 'h0000, 1,  1, 1, 'h0007, 0, 1, 1, 3);

`ifdef SAMPLE_FRAMER_TWOS_COMP_EN
    tc_exp[0] = 14'h0000; tc_exp[1] = 14'h2000; tc_exp[2] = 14'h1FFF;
`else
    tc_exp[0] = 14'h2000; tc_exp[1] = 14'h0000; tc_exp[2] = 14'h3FFF;
`endif

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].wv, vecs[i].word, vecs[i].sr);
      #1;
      chk($sformatf("v%0d.word_ready", i), bus.word_ready, vecs[i].e_wr);
      chk($sformatf("v%0d.sample_valid", i), bus.sample_valid, vecs[i].e_sv);
      if (vecs[i].e_sv) begin
        chk($sformatf("v%0d.sample_data", i), bus.sample_data, xf(vecs[i].e_word));
        chk($sformatf("v%0d.sample_last", i), bus.sample_last, vecs[i].e_last);
      end
      chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d.pad_err", i), pad_err, vecs[i].e_pad);
      chk($sformatf("v%0d.frame_count", i), frame_count, vecs[i].e_fc);
      tick();
    end

    // Fill the buffer to 2 under backpressure, then reset mid-frame.
    drive(0, 0, 1, 'h0031, 0); #1;
    chk("rst_fill.wr0", bus.word_ready, 1);
    tick();
    drive(0, 0, 1, 'h0032, 0); #1;
    chk("rst_fill.wr1", bus.word_ready, 1);
    tick();
    drive(0, 0, 1, 'h0033, 0); #1;
    chk("rst_fill.full", bus.word_ready, 0);
    chk("rst_fill.head", bus.sample_data, xf('h0031));
    chk("rst_fill.last", bus.sample_last, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst.sample_valid", bus.sample_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.frame_count", frame_count, 0);
    chk("rst.pad_err", pad_err, 0);
    chk("rst.word_ready", bus.word_ready, 0);

    drive(1, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, (k < 4) ? 1 : 0, 'h0041 + k, 1);
      #1;
      if (k == 0) begin
        chk("restart.sv0", bus.sample_valid, 0);
      end else begin
        chk($sformatf("restart.sv%0d", k), bus.sample_valid, 1);
        chk($sformatf("restart.data%0d", k), bus.sample_data, xf(16'(32'h41 + k - 1)));
        chk($sformatf("restart.last%0d", k), bus.sample_last, (k == 4) ? 1 : 0);
      end
      tick();
    end
    drive(0, 0, 0, 0, 1); #1;
    chk("restart.frame_count", frame_count, 1);
    tick();

    // Offset-binary boundary words.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, (k < 3) ? 1 : 0, (k == 0) ? 'h2000 : (k == 1) ? 'h0000 : 'h3FFF, 1);
      #1;
      if (k > 0) begin
        chk($sformatf("conv.sv%0d", k), bus.sample_valid, 1);
        chk($sformatf("conv.data%0d", k), bus.sample_data, tc_exp[k-1]);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Sits directly downstream of the DCO-domain word assembler.
- Consumes its 16-bit assembled words over a valid/ready handshake and strips the two pad bits to get 14-bit ADC samples.
- Groups samples into fixed-length frames with a last marker and presents them on a valid/ready sample stream toward the capture FIFO/DMA.
- Start/stop control always yields whole frames; a 2-entry buffer decouples upstream ready from downstream backpressure.

Parameters:
- WORD_W, 16, input word width (bits [15:14] are pad, must be 0).
- SAMPLE_W, 14, output sample width (bits [13:0] of word).
- FRAME_LEN, 256, samples per frame; legal range 1..65535.
- FRAME_CNT_W, 16, width of completed-frame counter.

Ports:
- dco_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begin framing.
- stop  in  1  single-cycle pulse; stop at next frame boundary.
- word  in  WORD_W  assembled word.
- word_valid  in  1  word is valid.
- word_ready  out  1  framer accepts word this cycle.
- sample_data  out  SAMPLE_W  output sample.
- sample_valid  out  1  sample_data/sample_last valid.
- sample_ready  in  1  downstream accepts.
- sample_last  out  1  final sample of a frame.
- busy  out  1  state != IDLE.
- pad_err  out  1  sticky: a word with nonzero pad bits was accepted.
- frame_count  out  FRAME_CNT_W  frames fully delivered downstream.

Behaviour:
- Clock and reset: one clock, dco_clk. Reset is synchronous and active-high on rst. While rst=1 at a dco_clk edge: state=IDLE, buffer emptied, sample index=0, stop_pending=0, pad_err=0, frame_count=0; hence word_ready=0, sample_valid=0, sample_last=0, busy=0. Reset mid-frame discards buffered samples; no sample_last is emitted for the partial frame.
- States IDLE / RUN / DRAIN:
  - IDLE: start=1 -> RUN next cycle with index=0. stop is ignored.
  - RUN: start is ignored. stop=1 sets stop_pending. When a word is accepted with index==FRAME_LEN-1 and (stop_pending or stop this cycle) -> DRAIN, clearing stop_pending.
  - DRAIN: word_ready=0. When the buffer is empty -> IDLE.
- Input handshake:
  - word_ready = (state==RUN) && (fill<2). It is a function of registers only; there is no combinational path from sample_ready or word_valid.
  - A transfer occurs on word_valid && word_ready.
  - Accepted word stores {last = (index==FRAME_LEN-1), data = word[13:0]}.
  - index increments per transfer and wraps to 0 after FRAME_LEN-1. With FRAME_LEN=1 every sample is last.
  - A transfer with word[15:14] != 0 sets pad_err, which holds until rst. The sample is still forwarded.
- Buffer: 2-entry FIFO, in-order. A push and pop in the same cycle at fill=2 is legal; fill stays 2 and word_ready stays 0 that cycle.
- Output:
  - sample_valid = (fill != 0); data/last come from the head entry.
  - Once sample_valid is high, head data and last stay stable until sample_ready=1.
  - Latency: an accepted word appears on sample_* the next cycle when the buffer was empty.
  - With continuous valid/ready, throughput is 1 sample per clock.
- frame_count increments on each output transfer with sample_last=1 and wraps modulo 2^FRAME_CNT_W.
- start and stop asserted together in IDLE: enter RUN, and stop is ignored. In RUN both behave as a stop.

Optional Feature:
- Macro: SAMPLE_FRAMER_TWOS_COMP_EN.
- Defined: the stored sample has bit SAMPLE_W-1 inverted, converting offset-binary to two's complement (word 0x2000 -> sample 0x0000, word 0x0000 -> sample 0x2000).
- Not defined: word[13:0] passes unchanged.
- Handshake, timing and pad_err are identical in both builds.

Decomposition:
- Package adc_frontend_pkg holds:
  - constants ADC_WORD_W=16, ADC_SAMPLE_W=14, ADC_PAD_W=2;
  - typedef enum logic[1:0] framer_state_t {FR_IDLE, FR_RUN, FR_DRAIN};
  - typedef struct packed {logic last; logic [13:0] data;} sample_entry_t.
- One sub-module: sample_skid_fifo, a 2-entry single-clock FIFO of sample_entry_t with push/pop/fill, synchronous active-high rst.
- Framing FSM, index counter and frame counter stay in sample_framer.

Test Plan:
- Basic flow: FRAME_LEN=4, start, words 0x0001..0x0004 back-to-back, sample_ready=1 -> samples 0x0001..0x0004 each one cycle after acceptance; sample_last only on 0x0004; frame_count=1.
- Backpressure: sample_ready=0, feed 3 words -> exactly 2 accepted, word_ready=0 on the third; sample_data holds 0x0001; on release, order is 0x0001, 0x0002, 0x0003 with no loss or duplication.
- Stop mid-frame: FRAME_LEN=4, stop after the 2nd sample -> samples 3 and 4 still accepted, then DRAIN; busy drops after the 4th output transfer; frame_count=1; a 5th word is never accepted.
- Pad error: accept word 0xC005 -> sample 0x0005 forwarded, pad_err=1 and stays 1 through later clean words until rst.
- Reset mid-frame: rst=1 with fill=2 -> next cycle sample_valid=0, busy=0, frame_count=0; a new start restarts index so sample_last lands on the FRAME_LEN-th new sample.
- Optional build with SAMPLE_FRAMER_TWOS_COMP_EN: words 0x2000, 0x0000, 0x3FFF -> samples 0x0000, 0x2000, 0x1FFF.
